// File: rtl/y_sram_access_sched_pkg.sv
// Shared encodings and defaults for the Y SRAM access scheduler.
package y_sram_access_sched_pkg;

  localparam int unsigned DEFAULT_TURNAROUND = 1;
  localparam int unsigned DEFAULT_MAX_HOLD   = 64;
  localparam int unsigned DEFAULT_HOLD_W     = 7;
  localparam int unsigned TURN_W             = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CP_OWN = 2'd1,
    WP_OWN = 2'd2,
    TURN   = 2'd3
  } schedState_t;

  typedef enum logic {
    OWNER_CP = 1'b0,
    OWNER_WP = 1'b1
  } owner_t;

  // Winner among active requesters; on a tie the side that did not own last wins.
  function automatic owner_t pickOwner(input logic cpReq, input logic wpReq,
                                       input owner_t lastOwner);
    if (cpReq && wpReq) begin
      return (lastOwner == OWNER_CP) ? OWNER_WP : OWNER_CP;
    end else if (cpReq) begin
      return OWNER_CP;
    end else begin
      return OWNER_WP;
    end
  endfunction

endpackage

// File: rtl/y_sram_access_sched.sv
// Owns the Y SRAM port: arbitrates compute vs write-back requesters with a
// blocked-write turnaround gap between owners and an optional hold limit.
module y_sram_access_sched
  import y_sram_access_sched_pkg::*;
#(
  parameter int unsigned TURNAROUND = DEFAULT_TURNAROUND,
  parameter int unsigned MAX_HOLD   = DEFAULT_MAX_HOLD,
  parameter int unsigned HOLD_W     = DEFAULT_HOLD_W
) (
  input  logic clk,
  input  logic reset,
  input  logic in_cpReq,
  input  logic in_cpDone,
  input  logic in_wpReq,
  input  logic in_wpDone,
  output logic op_cpGrant,
  output logic op_wpGrant,
  output logic op_yComputeModuleEnable,
  output logic op_yWriteModuleEnable,
  output logic op_weBlock,
  output logic op_preempt
);

  localparam logic [TURN_W-1:0] TURN_LAST  = TURN_W'(TURNAROUND - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit                HOLD_LIMIT = (MAX_HOLD != 0);

  schedState_t       state, stateNext;
  owner_t            lastOwner, lastOwnerNext;
  logic [HOLD_W-1:0] holdCnt, holdCntNext;
  logic [TURN_W-1:0] turnCnt, turnCntNext;
  logic              cpGrantNext, wpGrantNext, preemptNext;
  logic              arbitrate;
  logic              ownReq, ownDone, otherReq, forceRel;
  owner_t            winner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lastOwner  <= OWNER_WP;
      holdCnt    <= '0;
      turnCnt    <= '0;
      op_cpGrant <= 1'b0;
      op_wpGrant <= 1'b0;
      op_weBlock <= 1'b1;
      op_preempt <= 1'b0;
    end else begin
      state      <= stateNext;
      lastOwner  <= lastOwnerNext;
      holdCnt    <= holdCntNext;
      turnCnt    <= turnCntNext;
      op_cpGrant <= cpGrantNext;
      op_wpGrant <= wpGrantNext;
      op_weBlock <= ~(cpGrantNext | wpGrantNext);
      op_preempt <= preemptNext;
    end
  end

  // Enables are the grant flops themselves, so they can never disagree.
  assign op_yComputeModuleEnable = op_cpGrant;
  assign op_yWriteModuleEnable   = op_wpGrant;

  always_comb begin
    stateNext     = state;
    lastOwnerNext = lastOwner;
    holdCntNext   = holdCnt;
    turnCntNext   = turnCnt;
    cpGrantNext   = 1'b0;
    wpGrantNext   = 1'b0;
    preemptNext   = 1'b0;
    arbitrate     = 1'b0;
    winner        = pickOwner(in_cpReq, in_wpReq, lastOwner);

    ownReq   = (state == WP_OWN) ? in_wpReq  : in_cpReq;
    ownDone  = (state == WP_OWN) ? in_wpDone : in_cpDone;
    otherReq = (state == WP_OWN) ? in_cpReq  : in_wpReq;
    forceRel = HOLD_LIMIT && otherReq && (holdCnt == HOLD_LAST);

    case (state)
      IDLE: arbitrate = 1'b1;
      CP_OWN, WP_OWN: begin
        if (ownDone || !ownReq || forceRel) begin
          stateNext     = TURN;
          turnCntNext   = '0;
          lastOwnerNext = (state == WP_OWN) ? OWNER_WP : OWNER_CP;
          preemptNext   = forceRel && ownReq && !ownDone;
        end else begin
          cpGrantNext = (state == CP_OWN);
          wpGrantNext = (state == WP_OWN);
          holdCntNext = (holdCnt == '1) ? holdCnt : holdCnt + HOLD_W'(1);
        end
      end
      TURN: begin
        if (turnCnt == TURN_LAST) begin
          arbitrate = 1'b1;
        end else begin
          turnCntNext = turnCnt + TURN_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    // Shared grant decision for IDLE and the final turnaround cycle.
    if (arbitrate) begin
      if (in_cpReq || in_wpReq) begin
        holdCntNext = '0;
        if (winner == OWNER_CP) begin
          stateNext   = CP_OWN;
          cpGrantNext = 1'b1;
        end else begin
          stateNext   = WP_OWN;
          wpGrantNext = 1'b1;
        end
      end else begin
        stateNext = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_y_sram_access_sched.sv
// Directed bench for the Y SRAM access scheduler (TURNAROUND=2, MAX_HOLD=4).
module tb_y_sram_access_sched;
  import y_sram_access_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic cpReq, cpDone, wpReq, wpDone;
  logic cpGrant, wpGrant, cpEn, wpEn, weBlock, preempt;
  int   errors = 0;
  int   checks = 0;

  y_sram_access_sched #(.TURNAROUND(2), .MAX_HOLD(4), .HOLD_W(3)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .in_cpReq                (cpReq),
    .in_cpDone               (cpDone),
    .in_wpReq                (wpReq),
    .in_wpDone               (wpDone),
    .op_cpGrant              (cpGrant),
    .op_wpGrant              (wpGrant),
    .op_yComputeModuleEnable (cpEn),
    .op_yWriteModuleEnable   (wpEn),
    .op_weBlock              (weBlock),
    .op_preempt              (preempt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // {cpGrant, wpGrant, cpEn, wpEn, weBlock, preempt}
  task automatic expOut(input string tag, input logic [5:0] exp);
    checkVal(tag, {2'b00, cpGrant, wpGrant, cpEn, wpEn, weBlock, preempt}, {2'b00, exp});
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    cpReq = 0; cpDone = 0; wpReq = 0; wpDone = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1);
  endtask

  // Invariants sampled away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      checkVal("exclusive", {7'd0, cpGrant & wpGrant}, 8'd0);
      checkVal("enMirror", {6'd0, cpEn, wpEn}, {6'd0, cpGrant, wpGrant});
      if (dut.state == TURN) checkVal("turnNoGrant", {6'd0, cpGrant, wpGrant}, 8'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cpReq = 0; cpDone = 0; wpReq = 0; wpDone = 0;
    doReset();
    expOut("resetState", 6'b000010);

    // 1: single CP ownership, held past the hold limit with no competitor
    cpReq = 1;
    step(1);
    expOut("cpGrantLatency", 6'b101000);
    step(5);
    expOut("cpHoldNoLimit", 6'b101000);
    cpDone = 1;
    step(1);
    cpDone = 0; cpReq = 0;
    expOut("cpRelease", 6'b000010);
    step(3);

    // 2: tie after reset goes to CP; WP granted TURNAROUND+1 after done
    doReset();
    cpReq = 1; wpReq = 1;
    step(1);
    expOut("tieCpFirst", 6'b101000);
    step(1);
    cpDone = 1;
    step(1);
    cpDone = 0; cpReq = 0;
    expOut("tieCpRelease", 6'b000010);
    step(1);
    expOut("turnGap", 6'b000010);
    step(1);
    expOut("wpAfterTurn", 6'b010100);
    wpDone = 1; wpReq = 0;
    step(1);
    wpDone = 0;
    expOut("wpRelease", 6'b000010);
    step(3);

    // 3: hold limit preempts CP after 4 owned cycles
    cpReq = 1;
    step(1);
    expOut("cpOwnPre", 6'b101000);
    wpReq = 1;
    step(3);
    expOut("cpStillOwned", 6'b101000);
    step(1);
    cpReq = 0;
    expOut("preemptPulse", 6'b000011);
    step(1);
    expOut("preemptOnce", 6'b000010);
    step(1);
    expOut("wpAfterPreempt", 6'b010100);
    wpDone = 1; wpReq = 0;
    step(1);
    wpDone = 0;
    step(3);

    // 4: stray dones are ignored
    cpDone = 1;
    step(1);
    cpDone = 0;
    expOut("idleDoneIgnored", 6'b000010);
    cpReq = 1;
    step(1);
    expOut("cpOwn4", 6'b101000);
    wpDone = 1;
    step(1);
    wpDone = 0;
    expOut("otherDoneIgnored", 6'b101000);
    step(1);
    expOut("cpStillOwn4", 6'b101000);

    // 5: dropping req without done releases
    cpReq = 0;
    step(1);
    expOut("reqDropRelease", 6'b000010);
    step(3);

    // 6: async reset mid WP ownership, then tie goes to CP again
    wpReq = 1;
    step(1);
    expOut("wpOwn6", 6'b010100);
    step(1);
    #1 reset = 1'b0;
    #1;
    expOut("asyncReset", 6'b000010);
    wpReq = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1);
    expOut("postReset", 6'b000010);
    cpReq = 1; wpReq = 1;
    step(1);
    expOut("tieAfterReset", 6'b101000);
    cpReq = 0; wpReq = 0;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
